// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the FIFO read adapter.
// Build option: define FIFO_RD_ADAPTER_BEATCNT_EN to enable the accepted-beat counter.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_RD_LATENCY = 1;

   // Bits needed to hold a count from 0 up to and including depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer with a registered head word, used as the adapter's skid storage.
// Callers guarantee no push when full and no pop when empty.
module fifo_rd_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_RD_LATENCY + 1,
   localparam int CNT_W     = cnt_width(DEPTH),
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CNT_W-1:0]      occ
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      head_d   = head_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
         // Reading mem_d lets a word written this cycle become the head immediately.
         if (occ_d != '0) begin
            head_d = mem_d[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head = head_q;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns a fixed-latency sync FIFO read port into a valid/ready stream with a credit-limited skid buffer.
// Build option: define FIFO_RD_ADAPTER_BEATCNT_EN to enable the accepted-beat counter.
module fifo_rd_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fifo_empty,
   output logic                  pop,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [31:0]           beat_count
);

   localparam int BUF_DEPTH = RD_LATENCY + 1;
   localparam int CNT_W     = cnt_width(BUF_DEPTH);

   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   logic [CNT_W-1:0]      occ;
   logic [CNT_W:0]        credit_used;
   logic                  capture;
   logic                  xfer;

   assign xfer    = m_valid & m_ready;
   assign capture = pipe_q[RD_LATENCY-1] & ~flush;
   assign m_valid = reset_n & (occ != '0);

   // The head leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
   always_comb begin
      credit_used = {1'b0, occ} + {1'b0, inflight_q} - (CNT_W + 1)'(xfer);
      pop = reset_n & ~fifo_empty & ~flush & (credit_used < (CNT_W + 1)'(BUF_DEPTH));
      pipe_d     = '0;
      inflight_d = '0;
      if (!flush) begin
         pipe_d     = (pipe_q << 1) | RD_LATENCY'(pop);
         inflight_d = inflight_q + CNT_W'(pop) - CNT_W'(pipe_q[RD_LATENCY-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pipe_q     <= '0;
         inflight_q <= '0;
      end else begin
         pipe_q     <= pipe_d;
         inflight_q <= inflight_d;
      end
   end

   fifo_rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (flush),
      .push      (capture),
      .push_data (rd_data),
      .pop       (xfer),
      .head      (m_data),
      .occ       (occ)
   );

`ifdef FIFO_RD_ADAPTER_BEATCNT_EN
   logic [31:0] beat_count_q, beat_count_d;

   // Survives flush on purpose; only reset clears the running total.
   always_comb begin
      beat_count_d = beat_count_q + 32'(xfer);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         beat_count_q <= '0;
      end else begin
         beat_count_q <= beat_count_d;
      end
   end

   assign beat_count = beat_count_q;
`else
   assign beat_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: one instance at read latency 1 and one at read latency 2,
// each fed by a simple upstream FIFO model with the matching return delay.
module tb_fifo_rd_adapter;

   localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n, flush, m_ready;
   logic        fifo_empty1, pop1, m_valid1;
   logic [31:0] rd_data1, m_data1, beat_count1;
   logic        fifo_empty2, pop2, m_valid2;
   logic [31:0] rd_data2, m_data2, beat_count2;

   always #5 clk = ~clk;

   fifo_rd_adapter #(.DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty1), .pop(pop1),
      .rd_data(rd_data1), .flush(flush), .m_valid(m_valid1), .m_ready(m_ready),
      .m_data(m_data1), .beat_count(beat_count1)
   );

   fifo_rd_adapter #(.DATA_WIDTH(32), .RD_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty2), .pop(pop2),
      .rd_data(rd_data2), .flush(flush), .m_valid(m_valid2), .m_ready(m_ready),
      .m_data(m_data2), .beat_count(beat_count2)
   );

   logic [31:0] src1 [64];
   logic [31:0] src2 [64];
   int          cnt1, rd1, cnt2, rd2;
   logic [31:0] stage2;
   logic        p1, p2;
   int          total, bad;

   typedef struct {
      logic        m_ready;
      logic        exp_pop;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [31:0] expBeats(input int n);
`ifdef FIFO_RD_ADAPTER_BEATCNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic setVec(input int i, input logic rdy, input logic p, input logic v, input logic [31:0] d);
      vecs[i] = '{m_ready: rdy, exp_pop: p, exp_valid: v, exp_data: d};
   endtask

   task automatic clearSrc();
      cnt1 = 0; rd1 = 0; cnt2 = 0; rd2 = 0;
      rd_data1 = GARBAGE; rd_data2 = GARBAGE; stage2 = GARBAGE;
      fifo_empty1 = 1'b1; fifo_empty2 = 1'b1;
   endtask

   task automatic loadSrc1(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) src1[cnt1 + i] = base + 32'(i);
      cnt1 += n;
      fifo_empty1 = (rd1 >= cnt1);
   endtask

   task automatic loadSrc2(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) src2[cnt2 + i] = base + 32'(i);
      cnt2 += n;
      fifo_empty2 = (rd2 >= cnt2);
   endtask

   // Drive this cycle's inputs just after the rising edge, then move to the falling edge for sampling.
   task automatic applyStimulus(input logic rst_n, input logic fl, input logic rdy);
      reset_n = rst_n;
      flush   = fl;
      m_ready = rdy;
      fifo_empty1 = (rd1 >= cnt1);
      fifo_empty2 = (rd2 >= cnt2);
      @(negedge clk);
   endtask

   // Upstream model: a pop returns its word 1 (dut1) or 2 (dut2) cycles later, otherwise garbage.
   task automatic finishCycle();
      logic [31:0] nxt;
      p1 = pop1;
      p2 = pop2;
      @(posedge clk);
      #1;
      rd_data1 = GARBAGE;
      if (p1 && rd1 < cnt1) begin
         rd_data1 = src1[rd1];
         rd1++;
      end
      nxt = GARBAGE;
      if (p2 && rd2 < cnt2) begin
         nxt = src2[rd2];
         rd2++;
      end
      rd_data2 = stage2;
      stage2   = nxt;
      fifo_empty1 = (rd1 >= cnt1);
      fifo_empty2 = (rd2 >= cnt2);
   endtask

   task automatic resetCycle();
      clearSrc();
      applyStimulus(1'b0, 1'b0, 1'b1);
      finishCycle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
      clearSrc();
      loadSrc1(8, 32'h100);

      // Backpressure run at latency 1: words 0x100.. with m_ready low for five cycles.
      setVec(0,  1'b1, 1'b1, 1'b0, 32'h0);
      setVec(1,  1'b1, 1'b1, 1'b0, 32'h0);
      setVec(2,  1'b1, 1'b1, 1'b1, 32'h100);
      setVec(3,  1'b0, 1'b0, 1'b1, 32'h101);
      setVec(4,  1'b0, 1'b0, 1'b1, 32'h101);
      setVec(5,  1'b0, 1'b0, 1'b1, 32'h101);
      setVec(6,  1'b0, 1'b0, 1'b1, 32'h101);
      setVec(7,  1'b0, 1'b0, 1'b1, 32'h101);
      setVec(8,  1'b1, 1'b1, 1'b1, 32'h101);
      setVec(9,  1'b1, 1'b1, 1'b1, 32'h102);
      setVec(10, 1'b1, 1'b1, 1'b1, 32'h103);
      setVec(11, 1'b1, 1'b1, 1'b1, 32'h104);
      setVec(12, 1'b1, 1'b1, 1'b1, 32'h105);
      setVec(13, 1'b1, 1'b0, 1'b1, 32'h106);
      setVec(14, 1'b1, 1'b0, 1'b1, 32'h107);
      setVec(15, 1'b1, 1'b0, 1'b0, 32'h0);

      @(posedge clk);
      #1;

      // Reset held with a non-empty upstream FIFO.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("rst%0d_pop", i), pop1, 32'd0);
         checkOutput($sformatf("rst%0d_valid", i), m_valid1, 32'd0);
         checkOutput($sformatf("rst%0d_data", i), m_data1, 32'd0);
         checkOutput($sformatf("rst%0d_beats", i), beat_count1, 32'd0);
         checkOutput($sformatf("rst%0d_pop2", i), pop2, 32'd0);
         finishCycle();
      end

      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b1, 1'b0, vecs[c].m_ready);
         checkOutput($sformatf("bp%0d_pop", c), pop1, 32'(vecs[c].exp_pop));
         checkOutput($sformatf("bp%0d_valid", c), m_valid1, 32'(vecs[c].exp_valid));
         if (vecs[c].exp_valid) checkOutput($sformatf("bp%0d_data", c), m_data1, vecs[c].exp_data);
         finishCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("bp_beats", beat_count1, expBeats(8));
      finishCycle();

      // Single word: pop in cycle 0, beat visible in cycle 2.
      resetCycle();
      loadSrc1(1, 32'hA5A5_0001);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("single_c0_pop", pop1, 32'd1);
      checkOutput("single_c0_valid", m_valid1, 32'd0);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("single_c1_pop", pop1, 32'd0);
      checkOutput("single_c1_valid", m_valid1, 32'd0);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("single_c2_valid", m_valid1, 32'd1);
      checkOutput("single_c2_data", m_data1, 32'hA5A5_0001);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("single_c3_valid", m_valid1, 32'd0);
      finishCycle();

      // Streaming 16 words at full rate.
      resetCycle();
      loadSrc1(16, 32'h0);
      for (int c = 0; c < 19; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkOutput($sformatf("st%0d_pop", c), pop1, 32'(c < 16));
         checkOutput($sformatf("st%0d_valid", c), m_valid1, 32'(c >= 2 && c < 18));
         if (c >= 2 && c < 18) checkOutput($sformatf("st%0d_data", c), m_data1, 32'(c - 2));
         finishCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("st_beats", beat_count1, expBeats(16));
      finishCycle();

      // Flush with one word buffered and one returning in the flush cycle.
      resetCycle();
      loadSrc1(4, 32'hF000);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fl_c0_pop", pop1, 32'd1);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fl_c1_pop", pop1, 32'd1);
      finishCycle();
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("fl_c2_pop", pop1, 32'd0);
      checkOutput("fl_c2_valid", m_valid1, 32'd1);
      checkOutput("fl_c2_data", m_data1, 32'hF000);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("fl_c3_valid", m_valid1, 32'd0);
      checkOutput("fl_c3_pop", pop1, 32'd1);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("fl_c4_valid", m_valid1, 32'd0);
      checkOutput("fl_c4_pop", pop1, 32'd1);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("fl_c5_valid", m_valid1, 32'd1);
      checkOutput("fl_c5_data", m_data1, 32'hF002);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("fl_c6_valid", m_valid1, 32'd1);
      checkOutput("fl_c6_data", m_data1, 32'hF003);
      finishCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("fl_c7_valid", m_valid1, 32'd0);
      finishCycle();

      // Latency 2: first beat three cycles after the first pop, then one per cycle.
      resetCycle();
      loadSrc2(8, 32'h200);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkOutput($sformatf("l2_%0d_pop", c), pop2, 32'(c < 8));
         checkOutput($sformatf("l2_%0d_valid", c), m_valid2, 32'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) checkOutput($sformatf("l2_%0d_data", c), m_data2, 32'h200 + 32'(c - 3));
         finishCycle();
      end

      // Latency 2: reset while a word is in flight; its late return must be ignored.
      resetCycle();
      loadSrc2(4, 32'h300);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("mr_c0_pop", pop2, 32'd1);
      finishCycle();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("mr_c1_pop", pop2, 32'd0);
      checkOutput("mr_c1_valid", m_valid2, 32'd0);
      finishCycle();
      rd2 = cnt2;
      for (int c = 2; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkOutput($sformatf("mr_c%0d_valid", c), m_valid2, 32'd0);
         checkOutput($sformatf("mr_c%0d_beats", c), beat_count2, expBeats(0));
         finishCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
